// File: rtl/divide_fsm.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results
// and divide-by-zero flag captured in registers with a one-cycle done pulse.
module divide_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enter,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    START = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           ps_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH:0]   rem_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH:0]   t_s;
  logic [WIDTH:0]   rem_nxt_s;
  logic [WIDTH-1:0] quo_nxt_s;
  logic [WIDTH-1:0] dvd_nxt_s;
  logic             ge_s;
  logic             last_s;

  // One shift-and-subtract step computed from the current iteration state.
  always_comb begin
    t_s  = {rem_r[WIDTH-1:0], dvd_r[WIDTH-1]};
    // rem_r[WIDTH] stays 0 because the remainder is always below the divisor;
    // it is kept as a guard bit so a set bit would still force a subtract.
    ge_s = rem_r[WIDTH] | (t_s >= {1'b0, dvs_r});
    if (ge_s) begin
      rem_nxt_s = t_s - {1'b0, dvs_r};
    end else begin
      rem_nxt_s = t_s;
    end
    quo_nxt_s = (quo_r << 1) | {{(WIDTH-1){1'b0}}, ge_s};
    dvd_nxt_s = dvd_r << 1;
    last_s    = (cnt_r == CW'(WIDTH-1));
  end

  // Control FSM with datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_r      <= HOLD;
      dvd_r     <= {WIDTH{1'b0}};
      dvs_r     <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      rem_r     <= {(WIDTH+1){1'b0}};
      cnt_r     <= {CW{1'b0}};
      quotient  <= {WIDTH{1'b0}};
      remainder <= {WIDTH{1'b0}};
      div_zero  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (ps_r)
        HOLD: begin
          done <= 1'b0;
          if (enter) begin
            ps_r <= START;
            busy <= 1'b1;
          end else begin
            ps_r <= HOLD;
            busy <= 1'b0;
          end
        end
        START: begin
          dvd_r <= A;
          dvs_r <= B;
          quo_r <= {WIDTH{1'b0}};
          rem_r <= {(WIDTH+1){1'b0}};
          cnt_r <= {CW{1'b0}};
          busy  <= 1'b1;
          if (B == {WIDTH{1'b0}}) begin
            ps_r      <= DONE;
            done      <= 1'b1;
            quotient  <= {WIDTH{1'b1}};
            remainder <= A;
            div_zero  <= 1'b1;
          end else begin
            ps_r <= ITER;
            done <= 1'b0;
          end
        end
        ITER: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          dvd_r <= dvd_nxt_s;
          cnt_r <= cnt_r + CW'(1);
          busy  <= 1'b1;
          if (last_s) begin
            ps_r      <= DONE;
            done      <= 1'b1;
            quotient  <= quo_nxt_s;
            remainder <= rem_nxt_s[WIDTH-1:0];
            div_zero  <= 1'b0;
          end else begin
            ps_r <= ITER;
            done <= 1'b0;
          end
        end
        DONE: begin
          ps_r <= HOLD;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          ps_r <= HOLD;
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide_fsm.sv
// Directed self-checking bench for divide_fsm (WIDTH=8).
module tb_divide_fsm;

  logic       clk;
  logic       rst_n;
  logic       enter;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_bad;

  divide_fsm #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enter(enter), .A(A), .B(B),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse enter for one cycle; cyc = cycle index (edge 0 = sampling edge) of done, -1 on timeout.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int cyc);
    bit found;
    @(negedge clk);
    A = a; B = b; enter = 1'b1;
    @(posedge clk);
    cyc = -1;
    found = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (!found) begin
        @(negedge clk);
        enter = 1'b0;
        if (done === 1'b1) begin
          cyc = k;
          found = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enter = 1'b0; A = 8'd0; B = 8'd0;
    #12;
    n_cmp++;
    if ({quotient, remainder, div_zero, busy, done} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_in: got q=%0d r=%0d dz=%0b busy=%0b done=%0b expected all 0",
               quotient, remainder, div_zero, busy, done);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({quotient, remainder, div_zero, busy, done} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_after: got q=%0d r=%0d dz=%0b busy=%0b done=%0b expected all 0",
               quotient, remainder, div_zero, busy, done);
    end
  endtask

  task automatic test_basic();
    int cyc;
    run_op(8'd100, 8'd7, cyc);
    n_cmp++;
    if (cyc !== 10) begin n_bad++; $display("FAIL basic_latency: got %0d expected 10", cyc); end
    n_cmp++;
    if ({quotient, remainder, div_zero} !== {8'd14, 8'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%0b expected q=14 r=2 dz=0", quotient, remainder, div_zero);
    end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_done: got %0b expected 1", busy); end
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL basic_after: got done=%0b busy=%0b expected 0 0", done, busy);
    end
  endtask

  task automatic test_extremes();
    logic [7:0] ta [3] = '{8'd255, 8'd5, 8'd255};
    logic [7:0] tb [3] = '{8'd1,   8'd9, 8'd255};
    logic [7:0] tq [3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0] tr [3] = '{8'd0,   8'd5, 8'd0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], cyc);
      n_cmp++;
      if (cyc !== 10 || {quotient, remainder, div_zero} !== {tq[i], tr[i], 1'b0}) begin
        n_bad++;
        $display("FAIL extreme_%0d: got cyc=%0d q=%0d r=%0d dz=%0b expected cyc=10 q=%0d r=%0d dz=0",
                 i, cyc, quotient, remainder, div_zero, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    run_op(8'd42, 8'd0, cyc);
    n_cmp++;
    if (cyc !== 2) begin n_bad++; $display("FAIL dz_latency: got %0d expected 2", cyc); end
    n_cmp++;
    if ({quotient, remainder, div_zero} !== {8'd255, 8'd42, 1'b1}) begin
      n_bad++;
      $display("FAIL dz_result: got q=%0d r=%0d dz=%0b expected q=255 r=42 dz=1", quotient, remainder, div_zero);
    end
    run_op(8'd84, 8'd4, cyc);
    n_cmp++;
    if (cyc !== 10 || {quotient, remainder, div_zero} !== {8'd21, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL dz_follow: got cyc=%0d q=%0d r=%0d dz=%0b expected cyc=10 q=21 r=0 dz=0",
               cyc, quotient, remainder, div_zero);
    end
  endtask

  task automatic test_busy_ignore();
    int n_done;
    int first;
    @(negedge clk);
    A = 8'd60; B = 8'd7; enter = 1'b1;
    @(posedge clk);
    n_done = 0; first = -1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) enter = 1'b0;
      if (k == 3) begin A = 8'd9; B = 8'd2; end
      if (k == 4) enter = 1'b1;
      if (k == 5) enter = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = k;
      end
    end
    n_cmp++;
    if (n_done !== 1 || first !== 10) begin
      n_bad++;
      $display("FAIL busy_ignore: got %0d done pulses first at %0d expected 1 at 10", n_done, first);
    end
    n_cmp++;
    if ({quotient, remainder} !== {8'd8, 8'd4}) begin
      n_bad++;
      $display("FAIL operand_latch: got q=%0d r=%0d expected q=8 r=4", quotient, remainder);
    end
  endtask

  task automatic test_reset_mid();
    int n_done;
    int cyc;
    @(negedge clk);
    A = 8'd200; B = 8'd13; enter = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      enter = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({quotient, remainder, div_zero, busy, done} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got q=%0d r=%0d dz=%0b busy=%0b done=%0b expected all 0",
               quotient, remainder, div_zero, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done !== 0 || quotient !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_no_done: got %0d active cycles q=%0d expected 0 q=0", n_done, quotient);
    end
    run_op(8'd200, 8'd13, cyc);
    n_cmp++;
    if (cyc !== 10 || {quotient, remainder, div_zero} !== {8'd15, 8'd5, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_recover: got cyc=%0d q=%0d r=%0d dz=%0b expected cyc=10 q=15 r=5 dz=0",
               cyc, quotient, remainder, div_zero);
    end
  endtask

  task automatic test_back_to_back();
    int d [3];
    int n;
    bit idle;
    d[0] = -1; d[1] = -1; d[2] = -1;
    @(negedge clk);
    A = 8'd50; B = 8'd6; enter = 1'b1;
    @(posedge clk);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      if (n < 3) begin
        @(negedge clk);
        if (done === 1'b1) begin
          d[n] = k;
          n++;
          if (n == 3) enter = 1'b0;
        end
      end
    end
    enter = 1'b0;
    n_cmp++;
    if (d[0] !== 10 || d[1] !== 21 || d[2] !== 32) begin
      n_bad++;
      $display("FAIL b2b_spacing: got done at %0d,%0d,%0d expected 10,21,32", d[0], d[1], d[2]);
    end
    n_cmp++;
    if ({quotient, remainder} !== {8'd8, 8'd2}) begin
      n_bad++;
      $display("FAIL b2b_result: got q=%0d r=%0d expected q=8 r=2", quotient, remainder);
    end
    idle = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy === 1'b0) idle = 1'b1;
    end
    n_cmp++;
    if (idle !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, eq, er;
    logic       edz;
    int         cyc, ecyc;
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i == 3) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) begin
        eq = 8'd255; er = a; edz = 1'b1; ecyc = 2;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0; ecyc = 10;
      end
      run_op(a, b, cyc);
      n_cmp++;
      if (cyc !== ecyc || {quotient, remainder, div_zero} !== {eq, er, edz}) begin
        n_bad++;
        $display("FAIL random_%0d (%0d/%0d): got cyc=%0d q=%0d r=%0d dz=%0b expected cyc=%0d q=%0d r=%0d dz=%0b",
                 i, a, b, cyc, quotient, remainder, div_zero, ecyc, eq, er, edz);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divide_fsm.md
# divide_fsm

Sequential unsigned divider for the calculator datapath. It is the inverse of the shift-and-add multiplier: it performs restoring shift-and-subtract division of A by B, one quotient bit per clock. It accepts operands on `enter` and reports quotient, remainder and a divide-by-zero flag, with a one-cycle `done` pulse that tells the downstream value register to capture the result.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width in bits.

- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `enter`  input  1  level-sensitive start request, sampled only in HOLD.
- `A`  input  WIDTH  dividend, unsigned.
- `B`  input  WIDTH  divisor, unsigned.
- `quotient`  output  WIDTH  registered result of A / B.
- `remainder`  output  WIDTH  registered result of A mod B.
- `div_zero`  output  1  registered; 1 when the last completed operation had B == 0.
- `busy`  output  1  high in every state except HOLD.
- `done`  output  1  single-cycle pulse in the DONE state.

## Operation
- Internal registers:
  - dividend shift register (WIDTH).
  - divisor (WIDTH).
  - partial remainder (WIDTH+1).
  - quotient shift register (WIDTH).
  - iteration counter (range 0..WIDTH-1).
  - PS.
- States and transitions:
  - HOLD: idle. If `enter`=1, go to START; otherwise stay in HOLD.
  - START:
    - Latch A into the dividend register and B into the divisor register.
    - Clear the partial remainder, the quotient register and the counter.
    - If B == 0, go to DONE with the zero flag set internally. Otherwise go to ITER.
  - ITER:
    - Form t = {partial_rem[WIDTH-1:0], dividend[WIDTH-1]}.
    - If t >= {1'b0, divisor}: partial_rem = t - divisor and shift a 1 into the quotient LSB.
    - Otherwise: partial_rem = t and shift a 0 into the quotient LSB.
    - Shift the dividend left by 1 and increment the counter.
    - After the iteration with counter == WIDTH-1, go to DONE.
  - DONE:
    - `done`=1 for this one cycle. Next state is HOLD.
    - On entry to DONE, update the output registers:
      - Normal case: `quotient`, `remainder` = partial_rem[WIDTH-1:0], `div_zero`=0.
      - Divide-by-zero case: `quotient` = all ones, `remainder` = latched A, `div_zero`=1.
  - Any illegal PS value: go to HOLD.
- Arithmetic is unsigned only. The compare and subtract are WIDTH+1 bits wide, so partial_rem never overflows.
- Operands are latched in START. Changes on A or B after START do not affect the operation in progress.
- `enter` is ignored while `busy`=1.
- If `enter` is still high when the block returns to HOLD, a new operation starts on the next edge. This matches the multiplier's level-sensitive behaviour.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - PS = HOLD.
  - `quotient`=0, `remainder`=0, `div_zero`=0, `busy`=0, `done`=0.
  - All internal registers = 0.
- Reset asserted mid-operation aborts the operation immediately. No `done` pulse is produced and the outputs read 0.
- Let edge 0 be the edge at which HOLD samples `enter`=1:
  - START occupies cycle 1.
  - ITER occupies cycles 2 to WIDTH+1.
  - DONE occupies cycle WIDTH+2. For WIDTH=8 this is 10 cycles after edge 0.
  - Results are valid from the start of the DONE cycle.
- Divide-by-zero path: START in cycle 1, DONE in cycle 2.
- Outputs hold their value until the next DONE entry or reset.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- `done` is never high for two consecutive cycles.

## Test plan
- Basic: WIDTH=8, A=100, B=7, pulse `enter` for 1 cycle -> `done` exactly 10 cycles later; `quotient`=14, `remainder`=2, `div_zero`=0.
- Extremes:
  - A=255, B=1 -> quotient=255, remainder=0.
  - A=5, B=9 -> quotient=0, remainder=5.
  - A=255, B=255 -> quotient=1, remainder=0.
- Divide by zero: A=42, B=0 -> `done` 2 cycles after `enter`; `quotient`=255, `remainder`=42, `div_zero`=1. A following 84/4 -> quotient=21, remainder=0, `div_zero`=0.
- Busy behaviour:
  - Pulse `enter` again at cycle 4 of an operation -> ignored; a single `done` pulse.
  - Change A and B mid-operation -> result reflects the operands latched in START.
- Reset mid-operation: assert `rst_n`=0 at cycle 5 -> all outputs 0 asynchronously, PS = HOLD, no `done`. After release, 200/13 -> quotient=15, remainder=5.
- Back-to-back: hold `enter` high continuously -> `done` pulses every 11 cycles (HOLD, START, 8×ITER, DONE).
- Random sweep: randomised A and B, checked against a reference model of A / B and A % B.
